// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
//
// Purpose:
//   Shared constants and types for the 32x64 architectural register file and
//   the blocks that sit around it (writeback arbiter, issue scoreboard).
//
// Contents:
//   REG_ADDR_W    - register address width
//   REG_DATA_W    - register data width
//   NUM_ARCH_REGS - number of architectural registers
//   reg_addr_t    - register address type
//   reg_data_t    - register data type
//   busy_vec_t    - one pending-write bit per architectural register
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int REG_ADDR_W    = 5;
  localparam int REG_DATA_W    = 64;
  localparam int NUM_ARCH_REGS = 32;

  typedef logic [REG_ADDR_W-1:0]    reg_addr_t;
  typedef logic [REG_DATA_W-1:0]    reg_data_t;
  typedef logic [NUM_ARCH_REGS-1:0] busy_vec_t;

endpackage : regfile_pkg

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//
// Purpose:
//   Round-robin arbiter for N requesters. The search for a winner starts at
//   the pointer and wraps around; the grant is one-hot and purely
//   combinational. When the owner signals a completed transfer on 'advance',
//   the pointer moves to the requester just after the winner, so that
//   winner has the lowest priority in the next cycle.
//
// Ports:
//   clk      in   1   clock, rising edge
//   reset    in   1   synchronous, active-low reset (pointer -> 0)
//   req      in   N   request vector
//   advance  in   1   the current grant was consumed this cycle
//   grant    out  N   one-hot grant, all zero when nothing requests
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_winIdx;
  logic             w_found;

  // Index of the requester that is k places after 'base', wrapping at N.
  function automatic logic [PTR_W-1:0] rotIdx(input logic [PTR_W-1:0] base,
                                              input int               k);
    int s;
    s = (int'(base) + k) % N;
    return PTR_W'(s);
  endfunction

  // Walk the requesters starting at the pointer; the first one found wins.
  always_comb begin
    w_found  = 1'b0;
    w_winIdx = '0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && req[rotIdx(r_ptr, k)]) begin
        w_found  = 1'b1;
        w_winIdx = rotIdx(r_ptr, k);
      end
    end
    grant = w_found ? (N'(1) << w_winIdx) : '0;
  end

  // Pointer moves past the winner only when its grant was actually used;
  // an idle or stalled cycle keeps the current priority order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ptr <= '0;
    end else if (advance && w_found) begin
      r_ptr <= (w_winIdx == PTR_W'(N - 1)) ? '0 : w_winIdx + PTR_W'(1);
    end
  end

endmodule : rr_arbiter

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose:
//   Owns the write port of the 32x64 register file. NUM_REQ writeback
//   sources (ALU, load, mov/immediate) compete round-robin for a single
//   registered write port. A pending-write scoreboard lets the issue stage
//   reserve destination registers and check sources for RAW hazards.
//
// Ports:
//   clk              in   1                 clock, rising edge
//   reset            in   1                 synchronous, active-low reset
//   req_valid        in   NUM_REQ           per-requester write request
//   req_addr         in   NUM_REQ*ADDR_W    packed dest addresses
//   req_data         in   NUM_REQ*DATA_W    packed write data
//   req_ready        out  NUM_REQ           one-hot grant
//   rsv_valid        in   1                 reserve a destination register
//   rsv_addr         in   ADDR_W            register to reserve
//   rsv_ready        out  1                 reservation accepted this cycle
//   chk_addr1/2      in   ADDR_W            source registers to check
//   chk_busy1/2      out  1                 source has a pending write
//   rf_write_enable  out  1                 register file write enable
//   rf_write_addr    out  ADDR_W            register file write address
//   rf_write_data    out  DATA_W            register file write data
//   busy_count       out  clog2(NUM_REGS+1) number of pending registers
//
// Build option:
//   WB_BYPASS_EN - when defined, adds fwd_data1/fwd_data2 outputs. A source
//   being written this very cycle reads as not busy and its value is
//   offered on fwd_dataN. When undefined, chk_busy drops one cycle after
//   the register file write.
// ---------------------------------------------------------------------------
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int NUM_REGS = NUM_ARCH_REGS,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int DATA_W   = REG_DATA_W,
  parameter int CNT_W    = $clog2(NUM_REGS + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      rsv_valid,
  input  logic [ADDR_W-1:0]         rsv_addr,
  output logic                      rsv_ready,
  input  logic [ADDR_W-1:0]         chk_addr1,
  input  logic [ADDR_W-1:0]         chk_addr2,
  output logic                      chk_busy1,
  output logic                      chk_busy2,
  output logic                      rf_write_enable,
  output logic [ADDR_W-1:0]         rf_write_addr,
  output logic [DATA_W-1:0]         rf_write_data,
  output logic [CNT_W-1:0]          busy_count
`ifdef WB_BYPASS_EN
  ,
  output logic [DATA_W-1:0]         fwd_data1,
  output logic [DATA_W-1:0]         fwd_data2
`endif
);

  // Arbiter connection
  logic [NUM_REQ-1:0] w_grant;
  logic               w_xfer;

  // Winner's payload
  logic [ADDR_W-1:0]  w_selAddr;
  logic [DATA_W-1:0]  w_selData;

  // Registered write port
  logic               r_wrEnable;
  logic [ADDR_W-1:0]  r_wrAddr;
  logic [DATA_W-1:0]  r_wrData;

  // Scoreboard
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busyNext;
  logic [CNT_W-1:0]    r_busyCount;
  logic [CNT_W-1:0]    w_busyCountNext;
  logic                w_rsvAccept;

  // -------------------------------------------------------------------------
  // Arbitration. The grant only looks at req_valid, never at the data.
  // -------------------------------------------------------------------------
  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .advance (w_xfer),
    .grant   (w_grant)
  );

  // Nobody is granted while reset is held; anything presented then is lost.
  assign req_ready = reset ? w_grant : '0;
  assign w_xfer    = |(req_valid & req_ready);

  // The grant is one-hot, so OR-ing the granted lanes selects the winner.
  always_comb begin
    w_selAddr = '0;
    w_selData = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_selAddr = w_selAddr | req_addr[i*ADDR_W +: ADDR_W];
        w_selData = w_selData | req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Write port register: a transfer in one cycle becomes the register file
  // write in the next. Address/data are held when idle so the port doesn't
  // toggle needlessly; only the enable matters then.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wrEnable <= 1'b0;
      r_wrAddr   <= '0;
      r_wrData   <= '0;
    end else begin
      r_wrEnable <= w_xfer;
      if (w_xfer) begin
        r_wrAddr <= w_selAddr;
        r_wrData <= w_selData;
      end
    end
  end

  assign rf_write_enable = r_wrEnable;
  assign rf_write_addr   = r_wrAddr;
  assign rf_write_data   = r_wrData;

  // -------------------------------------------------------------------------
  // Scoreboard. A register already waiting on a write cannot be reserved a
  // second time, which is what stalls WAW in the issue stage.
  // -------------------------------------------------------------------------
  assign rsv_ready   = reset & ~r_busy[rsv_addr];
  assign w_rsvAccept = rsv_valid & rsv_ready;

  // The clear is applied first and the set second, so a register that is
  // written back and re-reserved on the same edge stays busy for the new
  // producer.
  always_comb begin
    w_busyNext = r_busy;
    if (r_wrEnable) begin
      w_busyNext[r_wrAddr] = 1'b0;
    end
    if (w_rsvAccept) begin
      w_busyNext[rsv_addr] = 1'b1;
    end
  end

  // The count is taken from the next-state vector so it lands on the same
  // edge as the busy bits it describes.
  always_comb begin
    w_busyCountNext = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_busyCountNext = w_busyCountNext + CNT_W'(w_busyNext[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_busy      <= '0;
      r_busyCount <= '0;
    end else begin
      r_busy      <= w_busyNext;
      r_busyCount <= w_busyCountNext;
    end
  end

  assign busy_count = r_busyCount;

  // -------------------------------------------------------------------------
  // Source checks. Without bypass a source stays busy through the cycle the
  // register file is being written, because the file only holds the value
  // after that edge. With bypass the in-flight value is handed over directly.
  // -------------------------------------------------------------------------
  always_comb begin
    chk_busy1 = r_busy[chk_addr1];
    chk_busy2 = r_busy[chk_addr2];
`ifdef WB_BYPASS_EN
    fwd_data1 = '0;
    fwd_data2 = '0;
    if (r_wrEnable && (r_wrAddr == chk_addr1)) begin
      chk_busy1 = 1'b0;
      fwd_data1 = r_wrData;
    end
    if (r_wrEnable && (r_wrAddr == chk_addr2)) begin
      chk_busy2 = 1'b0;
      fwd_data2 = r_wrData;
    end
`endif
  end

endmodule : regfile_wb_arbiter
